// File: rtl/axi4_stream_frag_sched.sv
// axi4_stream_frag_sched: packet-level round-robin arbiter that lets several
// AXI4-Stream sources share one downstream fragmenter. A grant is held for a
// whole packet. The fragment size for the granted source is latched at grant time.
module axi4_stream_frag_sched #(
  parameter int N_SRC               = 4,
  parameter int TDATA_WIDTH         = 64,
  parameter int TID_WIDTH           = 1,
  parameter int TDEST_WIDTH         = 1,
  parameter int TUSER_WIDTH         = 1,
  parameter int MAX_FRAG_SIZE       = 2048,
  parameter int MAX_FRAG_SIZE_WIDTH = $clog2(MAX_FRAG_SIZE),
  parameter bit TDEST_FROM_SRC      = 1'b0
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic [N_SRC-1:0]                             src_en_i,
  input  logic [N_SRC*(MAX_FRAG_SIZE_WIDTH+1)-1:0]     frag_size_i,
  // source streams, source k occupies slice k of each vector
  input  logic [N_SRC-1:0]                             pkt_i_tvalid,
  output logic [N_SRC-1:0]                             pkt_i_tready,
  input  logic [N_SRC*TDATA_WIDTH-1:0]                 pkt_i_tdata,
  input  logic [N_SRC*(TDATA_WIDTH/8)-1:0]             pkt_i_tstrb,
  input  logic [N_SRC*(TDATA_WIDTH/8)-1:0]             pkt_i_tkeep,
  input  logic [N_SRC-1:0]                             pkt_i_tlast,
  input  logic [N_SRC*TID_WIDTH-1:0]                   pkt_i_tid,
  input  logic [N_SRC*TDEST_WIDTH-1:0]                 pkt_i_tdest,
  input  logic [N_SRC*TUSER_WIDTH-1:0]                 pkt_i_tuser,
  // stream towards the fragmenter
  output logic                                         pkt_o_tvalid,
  input  logic                                         pkt_o_tready,
  output logic [TDATA_WIDTH-1:0]                       pkt_o_tdata,
  output logic [(TDATA_WIDTH/8)-1:0]                   pkt_o_tstrb,
  output logic [(TDATA_WIDTH/8)-1:0]                   pkt_o_tkeep,
  output logic                                         pkt_o_tlast,
  output logic [TID_WIDTH-1:0]                         pkt_o_tid,
  output logic [TDEST_WIDTH-1:0]                       pkt_o_tdest,
  output logic [TUSER_WIDTH-1:0]                       pkt_o_tuser,
  output logic [MAX_FRAG_SIZE_WIDTH:0]                 max_frag_size_o,
  output logic [$clog2(N_SRC)-1:0]                     grant_o,
  output logic                                         busy_o
);

  localparam int GW = $clog2(N_SRC);
  localparam int SW = MAX_FRAG_SIZE_WIDTH + 1;
  localparam int KW = TDATA_WIDTH / 8;
  localparam logic [SW-1:0] MAX_SIZE = SW'(MAX_FRAG_SIZE);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [GW-1:0]   last_q;
  logic [GW-1:0]   grant_q;
  logic [SW-1:0]   max_q;
  logic [N_SRC-1:0] req;
  logic [GW-1:0]   winner;
  logic [GW-1:0]   cand;
  logic            found;
  logic [SW-1:0]   size_raw;
  logic [SW-1:0]   size_clean;
  logic            out_hs_last;

  assign req = pkt_i_tvalid & src_en_i;

  // Round-robin search starting just after the last winner, wrapping around
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      cand = GW'((int'(last_q) + i) % N_SRC);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Zero or oversized configuration falls back to the largest legal fragment
  always_comb begin
    size_raw   = frag_size_i[int'(winner)*SW +: SW];
    size_clean = size_raw;
    if (size_raw == '0 || size_raw > MAX_SIZE) begin
      size_clean = MAX_SIZE;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign out_hs_last = pkt_o_tvalid && pkt_o_tready && pkt_o_tlast;

  // Next state: grab a packet when anyone requests, release after its tlast beat
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (found) state_d = BUSY;
      BUSY: if (out_hs_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant, round-robin pointer and fragment size are captured only when a packet is won
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q  <= GW'(N_SRC - 1);
      grant_q <= '0;
      max_q   <= MAX_SIZE;
    end else if (state_q == IDLE && found) begin
      last_q  <= winner;
      grant_q <= winner;
      max_q   <= size_clean;
    end
  end

  // Only the granted source sees the downstream ready, and only while busy
  always_comb begin
    pkt_i_tready = '0;
    if (state_q == BUSY) begin
      pkt_i_tready[grant_q] = pkt_o_tready;
    end
  end

  assign pkt_o_tvalid = (state_q == BUSY) && pkt_i_tvalid[grant_q];
  assign pkt_o_tdata  = pkt_i_tdata[int'(grant_q)*TDATA_WIDTH +: TDATA_WIDTH];
  assign pkt_o_tstrb  = pkt_i_tstrb[int'(grant_q)*KW +: KW];
  assign pkt_o_tkeep  = pkt_i_tkeep[int'(grant_q)*KW +: KW];
  assign pkt_o_tlast  = pkt_i_tlast[grant_q];
  assign pkt_o_tid    = pkt_i_tid[int'(grant_q)*TID_WIDTH +: TID_WIDTH];
  assign pkt_o_tuser  = pkt_i_tuser[int'(grant_q)*TUSER_WIDTH +: TUSER_WIDTH];

  generate
    if (TDEST_FROM_SRC) begin : g_tdest_src
      assign pkt_o_tdest = TDEST_WIDTH'(grant_q);
    end else begin : g_tdest_pass
      assign pkt_o_tdest = pkt_i_tdest[int'(grant_q)*TDEST_WIDTH +: TDEST_WIDTH];
    end
  endgenerate

  assign max_frag_size_o = max_q;
  assign grant_o         = grant_q;
  assign busy_o          = (state_q == BUSY);

endmodule

// File: tb/tb_axi4_stream_frag_sched.sv
// tb_axi4_stream_frag_sched: directed tests for the packet round-robin scheduler
module tb_axi4_stream_frag_sched;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    src_en = 4'hF;
  logic [47:0]   frag_size = '0;
  logic [3:0]    in_valid = '0;
  logic [3:0]    in_ready;
  logic [255:0]  in_data = '0;
  logic [31:0]   in_strb = '0;
  logic [31:0]   in_keep = '0;
  logic [3:0]    in_last = '0;
  logic [3:0]    in_tid = '0;
  logic [3:0]    in_tdest = '0;
  logic [3:0]    in_tuser = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [63:0]   out_data;
  logic [7:0]    out_strb;
  logic [7:0]    out_keep;
  logic          out_last;
  logic          out_tid;
  logic          out_tdest;
  logic          out_tuser;
  logic [11:0]   max_size;
  logic [1:0]    grant;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // per-source beat memory ({tlast, tdata}) and received log
  logic [64:0] mem [4][64];
  int          head [4];
  int          tail [4];
  logic [83:0] rx [4][64];
  int          rx_n [4];
  int          glog [16];
  logic [11:0] mlog [16];
  int          gn;
  int          idle_log [16];
  int          idle_n;
  int          idle_cnt;
  bit          seen_pkt;
  int          anomalies;
  logic [3:0]  hold;
  bit          rand_gaps;
  bit          rand_ready;
  bit          prev_busy;
  bit          prev_out_valid;
  bit          prev_out_hs;
  bit          prev_rst;

  axi4_stream_frag_sched dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .src_en_i        (src_en),
    .frag_size_i     (frag_size),
    .pkt_i_tvalid    (in_valid),
    .pkt_i_tready    (in_ready),
    .pkt_i_tdata     (in_data),
    .pkt_i_tstrb     (in_strb),
    .pkt_i_tkeep     (in_keep),
    .pkt_i_tlast     (in_last),
    .pkt_i_tid       (in_tid),
    .pkt_i_tdest     (in_tdest),
    .pkt_i_tuser     (in_tuser),
    .pkt_o_tvalid    (out_valid),
    .pkt_o_tready    (out_ready),
    .pkt_o_tdata     (out_data),
    .pkt_o_tstrb     (out_strb),
    .pkt_o_tkeep     (out_keep),
    .pkt_o_tlast     (out_last),
    .pkt_o_tid       (out_tid),
    .pkt_o_tdest     (out_tdest),
    .pkt_o_tuser     (out_tuser),
    .max_frag_size_o (max_size),
    .grant_o         (grant),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [83:0] expand(input logic [64:0] b);
    logic [63:0] d;
    d = b[63:0];
    return {d, d[15:8], d[23:16], b[64], d[0], d[1], d[2]};
  endfunction

  function automatic logic [83:0] out_vec();
    return {out_data, out_keep, out_strb, out_last, out_tid, out_tdest, out_tuser};
  endfunction

  task automatic drive_front(input int k);
    logic [64:0] b;
    b = mem[k][head[k]];
    in_data[k*64 +: 64] = b[63:0];
    in_keep[k*8 +: 8]   = b[15:8];
    in_strb[k*8 +: 8]   = b[23:16];
    in_last[k]          = b[64];
    in_tid[k]           = b[0];
    in_tdest[k]         = b[1];
    in_tuser[k]         = b[2];
  endtask

  task automatic push_pkt(input int k, input int pid, input int n);
    for (int b = 0; b < n; b++) begin
      mem[k][tail[k]] = {(b == n - 1), 8'(k), 8'(pid), 8'(b), 8'h00, 32'($urandom)};
      tail[k]++;
    end
    if (!in_valid[k]) begin
      drive_front(k);
      in_valid[k] = 1'b1;
    end
    #1;
  endtask

  task automatic clear_all();
    for (int k = 0; k < 4; k++) begin
      head[k] = 0;
      tail[k] = 0;
      rx_n[k] = 0;
    end
    in_valid   = '0;
    hold       = '0;
    gn         = 0;
    idle_n     = 0;
    idle_cnt   = 0;
    seen_pkt   = 1'b0;
    anomalies  = 0;
    rand_gaps  = 1'b0;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    #1;
  endtask

  // One clock: record what happened this cycle, then advance the sources
  task automatic step();
    logic [3:0] pop;
    logic [3:0] exp_ready;
    bit         out_hs;
    #1;
    pop    = in_valid & in_ready;
    out_hs = out_valid && out_ready;
    if (busy && !prev_busy) begin
      glog[gn] = int'(grant);
      mlog[gn] = max_size;
      gn++;
      if (seen_pkt) begin
        idle_log[idle_n] = idle_cnt;
        idle_n++;
      end
      seen_pkt = 1'b1;
      idle_cnt = 0;
    end
    if (!busy) idle_cnt++;
    exp_ready = busy ? (4'(out_ready) << grant) : 4'b0000;
    if (in_ready !== exp_ready) anomalies++;
    if (out_hs) begin
      if (pop !== (4'b0001 << grant)) anomalies++;
      else begin
        rx[grant][rx_n[grant]] = out_vec();
        rx_n[grant]++;
      end
    end else if (pop !== 4'b0000) begin
      anomalies++;
    end
    if (prev_out_valid && !prev_out_hs && !out_valid && !prev_rst) anomalies++;
    for (int k = 0; k < 4; k++) if (pop[k]) head[k]++;
    hold           = in_valid & ~pop;
    prev_busy      = busy;
    prev_out_valid = out_valid;
    prev_out_hs    = out_hs;
    prev_rst       = rst;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (!hold[k]) begin
        in_valid[k] = (head[k] != tail[k]) && !(rand_gaps && $urandom_range(0, 2) == 0);
        if (head[k] != tail[k]) drive_front(k);
      end
    end
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_grants(input int n, output bit ok);
    int cnt;
    cnt = 0;
    while (gn < n && cnt < 200) begin
      step();
      cnt++;
    end
    ok = (gn >= n);
  endtask

  task automatic test_reset();
    clear_all();
    rst = 1'b1;
    step();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0h exp 0", busy); end
    checks++; if (grant !== 2'd0) begin errors++; $display("[TB] FAIL reset_grant got %0d exp 0", grant); end
    checks++; if (max_size !== 12'd2048) begin errors++; $display("[TB] FAIL reset_max got %0d exp 2048", max_size); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid got %0h exp 0", out_valid); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_tready got %b exp 0000", in_ready); end
    rst = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_req got %0h exp 0", busy); end
  endtask

  task automatic test_single_source();
    clear_all();
    src_en = 4'hF;
    frag_size = {12'd100, 12'd256, 12'd100, 12'd100};
    push_pkt(2, 0, 3);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_t got %0h exp 0", busy); end
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_t1 got %0h exp 1", busy); end
    checks++; if (grant !== 2'd2) begin errors++; $display("[TB] FAIL single_grant got %0d exp 2", grant); end
    checks++; if (max_size !== 12'd256) begin errors++; $display("[TB] FAIL single_max got %0d exp 256", max_size); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_first_valid got %0h exp 1", out_valid); end
    checks++; if (out_vec() !== expand(mem[2][0])) begin errors++; $display("[TB] FAIL single_first_beat got %h exp %h", out_vec(), expand(mem[2][0])); end
    step();
    step();
    checks++; if (out_last !== 1'b1) begin errors++; $display("[TB] FAIL single_tlast got %0h exp 1", out_last); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_after got %0h exp 0", busy); end
    checks++; if (rx_n[2] !== 3) begin errors++; $display("[TB] FAIL single_count got %0d exp 3", rx_n[2]); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rx[2][i] !== expand(mem[2][i])) begin errors++; $display("[TB] FAIL single_beat%0d got %h exp %h", i, rx[2][i], expand(mem[2][i])); end
    end
    checks++; if (anomalies !== 0) begin errors++; $display("[TB] FAIL single_handshake got %0d exp 0", anomalies); end
  endtask

  task automatic test_round_robin();
    int exp_g [6] = '{0, 1, 2, 3, 0, 1};
    int exp_n [4] = '{4, 4, 2, 2};
    clear_all();
    do_reset();
    src_en = 4'hF;
    push_pkt(0, 0, 2); push_pkt(0, 1, 2);
    push_pkt(1, 0, 2); push_pkt(1, 1, 2);
    push_pkt(2, 0, 2);
    push_pkt(3, 0, 2);
    for (int c = 0; c < 40; c++) step();
    checks++; if (gn !== 6) begin errors++; $display("[TB] FAIL rr_grant_count got %0d exp 6", gn); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (glog[i] !== exp_g[i]) begin errors++; $display("[TB] FAIL rr_grant%0d got %0d exp %0d", i, glog[i], exp_g[i]); end
    end
    checks++; if (idle_n !== 5) begin errors++; $display("[TB] FAIL rr_gap_count got %0d exp 5", idle_n); end
    for (int i = 0; i < idle_n && i < 16; i++) begin
      checks++; if (idle_log[i] !== 1) begin errors++; $display("[TB] FAIL rr_bubble%0d got %0d exp 1", i, idle_log[i]); end
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (rx_n[k] !== exp_n[k]) begin errors++; $display("[TB] FAIL rr_count_src%0d got %0d exp %0d", k, rx_n[k], exp_n[k]); end
      for (int i = 0; i < exp_n[k]; i++) begin
        checks++; if (rx[k][i] !== expand(mem[k][i])) begin errors++; $display("[TB] FAIL rr_beat_s%0d_%0d got %h exp %h", k, i, rx[k][i], expand(mem[k][i])); end
      end
    end
    checks++; if (anomalies !== 0) begin errors++; $display("[TB] FAIL rr_handshake got %0d exp 0", anomalies); end
  endtask

  task automatic test_enable_mask();
    int exp_g [5] = '{1, 3, 1, 3, 3};
    bit ok;
    clear_all();
    do_reset();
    src_en = 4'b1010;
    push_pkt(0, 0, 2);
    push_pkt(1, 0, 2); push_pkt(1, 1, 2); push_pkt(1, 2, 2);
    push_pkt(2, 0, 2);
    push_pkt(3, 0, 2); push_pkt(3, 1, 2); push_pkt(3, 2, 2);
    wait_grants(3, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL en_wait got %0d grants exp 3", gn); end
    src_en = 4'b1000;
    for (int c = 0; c < 30; c++) step();
    checks++; if (gn !== 5) begin errors++; $display("[TB] FAIL en_grant_count got %0d exp 5", gn); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (glog[i] !== exp_g[i]) begin errors++; $display("[TB] FAIL en_grant%0d got %0d exp %0d", i, glog[i], exp_g[i]); end
    end
    checks++; if (rx_n[0] !== 0) begin errors++; $display("[TB] FAIL en_src0 got %0d exp 0", rx_n[0]); end
    checks++; if (rx_n[1] !== 4) begin errors++; $display("[TB] FAIL en_src1 got %0d exp 4", rx_n[1]); end
    checks++; if (rx_n[2] !== 0) begin errors++; $display("[TB] FAIL en_src2 got %0d exp 0", rx_n[2]); end
    checks++; if (rx_n[3] !== 6) begin errors++; $display("[TB] FAIL en_src3 got %0d exp 6", rx_n[3]); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx[1][i] !== expand(mem[1][i])) begin errors++; $display("[TB] FAIL en_beat1_%0d got %h exp %h", i, rx[1][i], expand(mem[1][i])); end
    end
    checks++; if (anomalies !== 0) begin errors++; $display("[TB] FAIL en_handshake got %0d exp 0", anomalies); end
    src_en = 4'hF;
  endtask

  task automatic test_frag_size();
    bit ok;
    clear_all();
    do_reset();
    src_en = 4'hF;
    frag_size = {12'd100, 12'd100, 12'd100, 12'd0};
    push_pkt(0, 0, 1);
    wait_grants(1, ok);
    checks++; if (!ok || mlog[0] !== 12'd2048) begin errors++; $display("[TB] FAIL size_zero got %0d exp 2048", mlog[0]); end
    for (int c = 0; c < 3; c++) step();
    frag_size[11:0] = 12'd4000;
    push_pkt(0, 1, 4);
    wait_grants(2, ok);
    frag_size[11:0] = 12'd64;
    checks++; if (!ok || mlog[1] !== 12'd2048) begin errors++; $display("[TB] FAIL size_over got %0d exp 2048", mlog[1]); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (max_size !== 12'd2048) begin errors++; $display("[TB] FAIL size_hold%0d got %0d exp 2048", c, max_size); end
    end
    push_pkt(0, 2, 1);
    wait_grants(3, ok);
    checks++; if (!ok || mlog[2] !== 12'd64) begin errors++; $display("[TB] FAIL size_64 got %0d exp 64", mlog[2]); end
    for (int c = 0; c < 3; c++) step();
    frag_size[11:0] = 12'd2049;
    push_pkt(0, 3, 1);
    wait_grants(4, ok);
    checks++; if (!ok || mlog[3] !== 12'd2048) begin errors++; $display("[TB] FAIL size_2049 got %0d exp 2048", mlog[3]); end
    for (int c = 0; c < 3; c++) step();
    frag_size[11:0] = 12'd1;
    push_pkt(0, 4, 1);
    wait_grants(5, ok);
    checks++; if (!ok || mlog[4] !== 12'd1) begin errors++; $display("[TB] FAIL size_1 got %0d exp 1", mlog[4]); end
    for (int c = 0; c < 3; c++) step();
  endtask

  task automatic test_back_pressure();
    clear_all();
    do_reset();
    src_en = 4'hF;
    rand_gaps  = 1'b1;
    rand_ready = 1'b1;
    push_pkt(1, 0, 6);
    push_pkt(3, 0, 4);
    for (int c = 0; c < 120; c++) step();
    rand_gaps  = 1'b0;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    for (int c = 0; c < 20; c++) step();
    checks++; if (gn !== 2) begin errors++; $display("[TB] FAIL bp_grant_count got %0d exp 2", gn); end
    checks++; if (glog[0] !== 1) begin errors++; $display("[TB] FAIL bp_grant0 got %0d exp 1", glog[0]); end
    checks++; if (glog[1] !== 3) begin errors++; $display("[TB] FAIL bp_grant1 got %0d exp 3", glog[1]); end
    checks++; if (rx_n[1] !== 6) begin errors++; $display("[TB] FAIL bp_count1 got %0d exp 6", rx_n[1]); end
    checks++; if (rx_n[3] !== 4) begin errors++; $display("[TB] FAIL bp_count3 got %0d exp 4", rx_n[3]); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (rx[1][i] !== expand(mem[1][i])) begin errors++; $display("[TB] FAIL bp_beat1_%0d got %h exp %h", i, rx[1][i], expand(mem[1][i])); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx[3][i] !== expand(mem[3][i])) begin errors++; $display("[TB] FAIL bp_beat3_%0d got %h exp %h", i, rx[3][i], expand(mem[3][i])); end
    end
    checks++; if (anomalies !== 0) begin errors++; $display("[TB] FAIL bp_handshake got %0d exp 0", anomalies); end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    clear_all();
    do_reset();
    src_en = 4'hF;
    frag_size = {12'd100, 12'd100, 12'd500, 12'd300};
    push_pkt(2, 0, 5);
    wait_grants(1, ok);
    checks++; if (!ok || grant !== 2'd2) begin errors++; $display("[TB] FAIL rstmid_grant got %0d exp 2", grant); end
    checks++; if (out_vec() !== expand(mem[2][1])) begin errors++; $display("[TB] FAIL rstmid_beat2 got %h exp %h", out_vec(), expand(mem[2][1])); end
    push_pkt(0, 0, 2);
    rst = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got %0h exp 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_tvalid got %0h exp 0", out_valid); end
    checks++; if (grant !== 2'd0) begin errors++; $display("[TB] FAIL rstmid_grant0 got %0d exp 0", grant); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL rstmid_tready got %b exp 0000", in_ready); end
    checks++; if (max_size !== 12'd2048) begin errors++; $display("[TB] FAIL rstmid_max got %0d exp 2048", max_size); end
    rst = 1'b0;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rstrec_busy got %0h exp 1", busy); end
    checks++; if (grant !== 2'd0) begin errors++; $display("[TB] FAIL rstrec_grant got %0d exp 0", grant); end
    checks++; if (max_size !== 12'd300) begin errors++; $display("[TB] FAIL rstrec_max got %0d exp 300", max_size); end
    checks++; if (out_vec() !== expand(mem[0][0])) begin errors++; $display("[TB] FAIL rstrec_beat got %h exp %h", out_vec(), expand(mem[0][0])); end
    for (int c = 0; c < 20; c++) step();
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_round_robin();
    test_enable_mask();
    test_frag_size();
    test_back_pressure();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
